// File: rtl/mod_inverse_seq.sv
// Sequential modular inverse by iterative extended Euclid.
// A shared radix-2 restoring divider serves both the initial reduction and each quotient step.
module mod_inverse_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] modulo,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] inverse
);
    localparam int unsigned TW = WIDTH + 2;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RED, S_CHK, S_DIV, S_UPD, S_FIN} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mod_q, mod_d;
    logic [WIDTH-1:0]      r0_q, r0_d, r1_q, r1_d;
    logic [WIDTH-1:0]      quo_q, quo_d, rem_q, rem_d;
    logic signed [TW-1:0]  t0_q, t0_d, t1_q, t1_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [WIDTH-1:0]      inverse_q, inverse_d;

    logic [WIDTH-1:0]      divisor_c, step_rem_c, step_quo_c;
    logic [WIDTH:0]        trial_c, diff_c;
    logic                  ge_c, last_c;
    logic signed [TW-1:0]  q_s_c, prod_c, t0_adj_c;

    // One restoring-divider step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        divisor_c  = (state_q == S_RED) ? mod_q : r1_q;
        trial_c    = {rem_q, quo_q[WIDTH-1]};
        diff_c     = trial_c - {1'b0, divisor_c};
        ge_c       = (trial_c >= {1'b0, divisor_c});
        step_rem_c = ge_c ? WIDTH'(diff_c) : WIDTH'(trial_c);
        step_quo_c = {quo_q[WIDTH-2:0], ge_c};
        last_c     = (cnt_q == CW'(WIDTH - 1));
        q_s_c      = $signed({2'b00, quo_q});
        prod_c     = q_s_c * t1_q;
        t0_adj_c   = t0_q[TW-1] ? (t0_q + $signed({2'b00, mod_q})) : t0_q;
    end

    always_comb begin
        state_d   = state_q;
        mod_d     = mod_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        inverse_d = inverse_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mod_d     = modulo;
                    quo_d     = num;
                    rem_d     = '0;
                    cnt_d     = '0;
                    r0_d      = '0;
                    r1_d      = '0;
                    t0_d      = '0;
                    t1_d      = '0;
                    valid_d   = 1'b0;
                    inverse_d = '0;
                    state_d   = (num == '0 || modulo == '0) ? S_FIN : S_RED;
                end
            end
            S_RED: begin
                rem_d = step_rem_c;
                quo_d = step_quo_c;
                cnt_d = cnt_q + CW'(1);
                if (last_c) begin
                    r0_d    = mod_q;
                    r1_d    = step_rem_c;
                    t0_d    = '0;
                    t1_d    = TW'(1);
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (r1_q == '0) begin
                    valid_d   = (r0_q == WIDTH'(1));
                    inverse_d = (r0_q == WIDTH'(1)) ? WIDTH'(t0_adj_c) : '0;
                    state_d   = S_FIN;
                end else begin
                    rem_d   = '0;
                    quo_d   = r0_q;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = step_rem_c;
                quo_d = step_quo_c;
                cnt_d = cnt_q + CW'(1);
                if (last_c) state_d = S_UPD;
            end
            S_UPD: begin
                r0_d    = r1_q;
                r1_d    = rem_q;
                t0_d    = t1_q;
                t1_d    = t0_q - prod_c;
                state_d = S_CHK;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RED) || (state_d == S_CHK) ||
                 (state_d == S_DIV) || (state_d == S_UPD);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mod_q     <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            inverse_q <= '0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            inverse_q <= inverse_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign valid   = valid_q;
    assign inverse = inverse_q;
endmodule

// File: tb/tb_mod_inverse_seq.sv
// Bench for mod_inverse_seq: directed cases at WIDTH=64, randomized cases at WIDTH=16
// against a plain extended-Euclid reference model.
module tb_mod_inverse_seq;
    localparam int LIM64 = 20000;
    localparam int LIM16 = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s64, b64, d64, v64;
    logic [63:0] n64, m64, i64;
    logic        s16, b16, d16, v16;
    logic [15:0] n16, m16, i16;

    int n_checks = 0;
    int n_fail   = 0;

    mod_inverse_seq #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(s64), .num(n64), .modulo(m64),
        .busy(b64), .done(d64), .valid(v64), .inverse(i64)
    );
    mod_inverse_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .num(n16), .modulo(m16),
        .busy(b16), .done(d16), .valid(v16), .inverse(i16)
    );

    // Textbook extended Euclid; k = number of quotient steps taken.
    function automatic void ref_inv(input longint n, input longint m,
                                    output bit v, output longint inv, output int k);
        longint a, b, q, tmp, s0, s1;
        k = 0; v = 1'b0; inv = 0;
        if (n == 0 || m == 0) return;
        a = m; b = n % m; s0 = 0; s1 = 1;
        while (b != 0) begin
            q = a / b; tmp = a % b; a = b; b = tmp;
            tmp = s0 - q * s1; s0 = s1; s1 = tmp;
            k++;
        end
        v = (a == 1);
        if (v) inv = ((s0 % m) + m) % m;
    endfunction

    task automatic go64(input logic [63:0] n, input logic [63:0] m, output logic v,
                        output logic [63:0] inv, output int lat, output bit to, output logic bd);
        @(negedge clk); s64 = 1'b1; n64 = n; m64 = m;
        @(negedge clk); s64 = 1'b0; n64 = {$urandom, $urandom}; m64 = {$urandom, $urandom};
        lat = 1; to = 1'b0;
        while (!d64 && !to) begin
            if (lat >= LIM64) to = 1'b1;
            else begin @(negedge clk); lat++; end
        end
        v = v64; inv = i64; bd = b64;
    endtask

    task automatic go16(input logic [15:0] n, input logic [15:0] m, output logic v,
                        output logic [15:0] inv, output int lat, output bit to);
        @(negedge clk); s16 = 1'b1; n16 = n; m16 = m;
        @(negedge clk); s16 = 1'b0; n16 = 16'($urandom); m16 = 16'($urandom);
        lat = 1; to = 1'b0;
        while (!d16 && !to) begin
            if (lat >= LIM16) to = 1'b1;
            else begin @(negedge clk); lat++; end
        end
        v = v16; inv = i16;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s64 = 1'b0; s16 = 1'b0; n64 = '0; m64 = '0; n16 = '0; m16 = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({b64, d64, v64, i64} !== 67'd0) begin
            n_fail++; $display("FAIL reset64 got busy=%b done=%b valid=%b inv=%0h exp all 0", b64, d64, v64, i64);
        end
        n_checks++;
        if ({b16, d16, v16, i16} !== 19'd0) begin
            n_fail++; $display("FAIL reset16 got busy=%b done=%b valid=%b inv=%0h exp all 0", b16, d16, v16, i16);
        end
        rst_n = 1'b1;
    endtask

    // Directed 64-bit cases: {num, modulo}; expectations from the reference model.
    task automatic test_directed;
        longint cases [6][2] = '{'{3, 11}, '{20, 7}, '{10, 17}, '{6, 9}, '{5, 1}, '{0, 13}};
        logic v, bd; logic [63:0] inv; int lat, k, elat; bit to, ev; longint einv;
        for (int i = 0; i < 6; i++) begin
            ref_inv(cases[i][0], cases[i][1], ev, einv, k);
            elat = (cases[i][0] == 0) ? 1 : 66 * (k + 1);
            go64(64'(cases[i][0]), 64'(cases[i][1]), v, inv, lat, to, bd);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL dir%0d timeout after %0d cycles", i, lat); end
            n_checks++;
            if (v !== ev || inv !== 64'(einv)) begin
                n_fail++; $display("FAIL dir%0d got valid=%b inv=%0d exp valid=%b inv=%0d", i, v, inv, ev, einv);
            end
            n_checks++;
            if (lat != elat || bd !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_timing got lat=%0d busy=%b exp lat=%0d busy=0", i, lat, bd, elat);
            end
        end
    endtask

    task automatic test_edges;
        logic v, bd; logic [63:0] inv, mx; int lat; bit to;
        mx = '1;
        go64(mx - 64'd1, mx, v, inv, lat, to, bd);
        n_checks++;
        if (to || v !== 1'b1 || inv !== mx - 64'd1 || lat != 198) begin
            n_fail++; $display("FAIL max_width got valid=%b inv=%0h lat=%0d exp valid=1 inv=%0h lat=198", v, inv, lat, mx - 64'd1);
        end
        go64(64'd7, 64'd0, v, inv, lat, to, bd);
        n_checks++;
        if (to || v !== 1'b0 || inv !== 64'd0 || lat != 1) begin
            n_fail++; $display("FAIL mod_zero got valid=%b inv=%0d lat=%0d exp 0 0 1", v, inv, lat);
        end
    endtask

    // Valid/inverse clear at accept; busy rises the cycle after.
    task automatic test_clear_on_accept;
        logic v, bd; logic [63:0] inv; int lat; bit to;
        go64(64'd3, 64'd11, v, inv, lat, to, bd);
        @(negedge clk); s64 = 1'b1; n64 = 64'd20; m64 = 64'd7;
        @(negedge clk); s64 = 1'b0;
        n_checks++;
        if (v64 !== 1'b0 || i64 !== 64'd0 || b64 !== 1'b1) begin
            n_fail++; $display("FAIL clear_on_accept got valid=%b inv=%0d busy=%b exp 0 0 1", v64, i64, b64);
        end
        lat = 0;
        while (!d64 && lat < LIM64) begin @(negedge clk); lat++; end
        n_checks++;
        if (!d64 || i64 !== 64'd6) begin
            n_fail++; $display("FAIL clear_followup got done=%b inv=%0d exp 1 6", d64, i64);
        end
    endtask

    task automatic test_busy_ignore;
        int lat, ndone; logic v, bd; logic [63:0] inv; bit to;
        @(negedge clk); s64 = 1'b1; n64 = 64'd3; m64 = 64'd11;
        @(negedge clk); s64 = 1'b0;
        repeat (4) @(negedge clk);
        s64 = 1'b1; n64 = 64'd2; m64 = 64'd11;
        @(negedge clk); s64 = 1'b0;
        lat = 0;
        while (!d64 && lat < LIM64) begin @(negedge clk); lat++; end
        n_checks++;
        if (!d64 || v64 !== 1'b1 || i64 !== 64'd4) begin
            n_fail++; $display("FAIL busy_ignore got done=%b valid=%b inv=%0d exp 1 1 4", d64, v64, i64);
        end
        ndone = 0;
        repeat (400) begin @(negedge clk); if (d64) ndone++; end
        n_checks++;
        if (ndone != 0) begin n_fail++; $display("FAIL busy_ignore_extra got %0d done pulses exp 0", ndone); end
        go64(64'd10, 64'd17, v, inv, lat, to, bd);
        go64(64'd3, 64'd11, v, inv, lat, to, bd);
        n_checks++;
        if (to || v !== 1'b1 || inv !== 64'd4 || lat != 264) begin
            n_fail++; $display("FAIL back_to_back got valid=%b inv=%0d lat=%0d exp 1 4 264", v, inv, lat);
        end
    endtask

    task automatic test_reset_mid;
        int ndone, lat; logic v, bd; logic [63:0] inv; bit to;
        @(negedge clk); s64 = 1'b1; n64 = 64'd3; m64 = 64'd11;
        @(negedge clk); s64 = 1'b0;
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b64, d64, v64, i64} !== 67'd0) begin
            n_fail++; $display("FAIL reset_mid got busy=%b done=%b valid=%b inv=%0d exp all 0", b64, d64, v64, i64);
        end
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        repeat (400) begin @(negedge clk); if (d64 || b64) ndone++; end
        n_checks++;
        if (ndone != 0) begin n_fail++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", ndone); end
        go64(64'd10, 64'd17, v, inv, lat, to, bd);
        n_checks++;
        if (to || v !== 1'b1 || inv !== 64'd12) begin
            n_fail++; $display("FAIL reset_mid_fresh got valid=%b inv=%0d exp 1 12", v, inv);
        end
    endtask

    task automatic test_random16;
        logic [15:0] n, m, inv; logic v; int lat, k, elat; bit to, ev; longint einv;
        for (int i = 0; i < 150; i++) begin
            n = 16'($urandom);
            case (i % 4)
                0: m = 16'($urandom);
                1: m = 16'($urandom_range(1, 50));
                2: m = 16'd65521;
                default: m = 16'($urandom_range(2, 1000));
            endcase
            if (i == 7) n = 16'd0;
            if (i == 9) m = 16'd0;
            ref_inv(longint'(n), longint'(m), ev, einv, k);
            elat = (n == 0 || m == 0) ? 1 : 18 * (k + 1);
            go16(n, m, v, inv, lat, to);
            n_checks++;
            if (to || v !== ev || inv !== 16'(einv) || lat != elat) begin
                n_fail++;
                $display("FAIL rnd n=%0d m=%0d got valid=%b inv=%0d lat=%0d exp valid=%b inv=%0d lat=%0d",
                         n, m, v, inv, lat, ev, einv, elat);
            end
            if (v === 1'b1 && m > 16'd1) begin
                n_checks++;
                if ((longint'(n) * longint'(inv)) % longint'(m) != 1) begin
                    n_fail++; $display("FAIL rnd_product n=%0d m=%0d got inv=%0d product not 1", n, m, inv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_edges();
        test_clear_on_accept();
        test_busy_ignore();
        test_reset_mid();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
